// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: packs instruction descriptors into MIPS words and writes them to consecutive addresses.
// Optional `MIPS_ENC_DELAY_SLOT_EN inserts a NOP after every branch/jump.
module mips_instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              done_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              finished,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);
`ifdef MIPS_ENC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, FULL, DONE, ERROR} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q, addr_q;
  logic [ADDR_W:0]     count_q, cnt_nx, off;
  logic [31:0]         wdata_q, enc;
  logic [1:0]          err_code_q;
  logic                we_q, ins_q, legal, cti, full_nx;
  logic [15:0]         br_imm;
  logic [25:0]         rf, ifl;
  assign in_ready  = (state_q == LOAD) & ~ins_q;
  assign busy      = state_q == LOAD;
  assign finished  = (state_q == DONE) | (state_q == FULL);
  assign err       = state_q == ERROR;
  assign err_code  = err_code_q;
  assign count     = count_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cnt_nx    = count_q + (ADDR_W+1)'(1);
  assign full_nx   = cnt_nx[ADDR_W];
  // branch offset is relative to the word after the branch, sign-extended from ADDR_W+1 bits
  assign off       = {1'b0, in_target} - {1'b0, ptr_q} - (ADDR_W+1)'(1);
  assign br_imm    = 16'($signed(off));
  assign rf        = {in_rs, in_rt, in_rd, in_shamt};
  assign ifl       = {in_rs, in_rt, in_imm};
  always_comb begin
    enc = 32'h0;
    legal = 1'b1;
    cti = 1'b0;
    case (in_op)
      5'd0:  enc = {6'h00, rf, 6'h20};
      5'd1:  enc = {6'h00, rf, 6'h22};
      5'd2:  enc = {6'h00, rf, 6'h24};
      5'd3:  enc = {6'h00, rf, 6'h25};
      5'd4:  enc = {6'h00, rf, 6'h2a};
      5'd5:  enc = {6'h00, 5'h0, in_rt, in_rd, in_shamt, 6'h00};
      5'd6:  enc = {6'h00, 5'h0, in_rt, in_rd, in_shamt, 6'h02};
      5'd7:  begin enc = {6'h00, in_rs, 15'h0, 6'h08}; cti = 1'b1; end
      5'd8:  enc = {6'h08, ifl};
      5'd9:  enc = {6'h09, ifl};
      5'd10: enc = {6'h0c, ifl};
      5'd11: enc = {6'h0d, ifl};
      5'd12: enc = {6'h0a, ifl};
      5'd13: enc = {6'h0b, ifl};
      5'd14: enc = {6'h0f, 5'h0, in_rt, in_imm};
      5'd15: enc = {6'h23, ifl};
      5'd16: enc = {6'h2b, ifl};
      5'd17: enc = {6'h21, ifl};
      5'd18: enc = {6'h20, ifl};
      5'd19: enc = {6'h28, ifl};
      5'd20: enc = {6'h29, ifl};
      5'd21: begin enc = {6'h04, in_rs, in_rt, br_imm}; cti = 1'b1; end
      5'd22: begin enc = {6'h05, in_rs, in_rt, br_imm}; cti = 1'b1; end
      5'd23: begin enc = {6'h02, 26'(in_target)}; cti = 1'b1; end
      5'd24: begin enc = {6'h03, 26'(in_target)}; cti = 1'b1; end
      5'd25: enc = 32'h0;
      default: legal = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      ptr_q      <= ADDR_W'(BASE_ADDR);
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ins_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        state_q    <= LOAD;
        ptr_q      <= ADDR_W'(BASE_ADDR);
        count_q    <= '0;
        ins_q      <= 1'b0;
        err_code_q <= 2'b00;
      end else if (ins_q) begin
        we_q    <= 1'b1;
        addr_q  <= ptr_q;
        wdata_q <= 32'h0;
        ptr_q   <= ptr_q + ADDR_W'(1);
        count_q <= cnt_nx;
        ins_q   <= 1'b0;
        if (full_nx) state_q <= FULL;
        else if (done_in && state_q == LOAD) state_q <= DONE;
      end else if (state_q == LOAD) begin
        if (in_valid && !legal) begin
          state_q    <= ERROR;
          err_code_q <= 2'b01;
        end else begin
          if (in_valid) begin
            we_q    <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= enc;
            ptr_q   <= ptr_q + ADDR_W'(1);
            count_q <= cnt_nx;
            ins_q   <= DS & cti & ~full_nx;
          end
          state_q <= (in_valid && full_nx) ? FULL : done_in ? DONE : LOAD;
        end
      end else if (state_q == FULL && in_valid) begin
        state_q    <= ERROR;
        err_code_q <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder: directed scoreboard bench for the encoder (ADDR_W=8 main instance, ADDR_W=2 full-test instance).
module tb_mips_instr_encoder;
`ifdef MIPS_ENC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst, start, done_in, in_valid, start2, valid2;
  logic [4:0] op, rs, rt, rd, sh;
  logic [15:0] imm;
  logic [7:0] tgt;
  logic in_ready, mem_we, busy, finished, err;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0] err_code;
  logic [8:0] count;
  logic r2, we2, busy2, fin2, err2;
  logic [1:0] addr2, ec2;
  logic [31:0] wd2;
  logic [2:0] cnt2;
  int checks = 0, errors = 0, exp_ptr = 0, exp_cnt = 0;
  logic [63:0] q1[$], q2[$];

  mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .nrst(nrst), .start(start), .done_in(done_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_imm(imm), .in_target(tgt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .finished(finished),
    .err(err), .err_code(err_code), .count(count));

  mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .nrst(nrst), .start(start2), .done_in(1'b0), .in_valid(valid2), .in_ready(r2),
    .in_op(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_imm(imm), .in_target(tgt[1:0]),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2), .busy(busy2), .finished(fin2),
    .err(err2), .err_code(ec2), .count(cnt2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (q1.size() == 0) chk("dut_extra_write", 64'(q1.size()), 64'd1);
      else chk("dut_write", {24'h0, mem_addr, mem_wdata}, q1.pop_front());
    end
    if (we2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2_extra_write", 64'(q2.size()), 64'd1);
      else chk("dut2_write", {30'h0, addr2, wd2}, q2.pop_front());
    end
  end

  task automatic send(input logic [4:0] o, a, b, d, s, input logic [15:0] im, input logic [7:0] tg,
                      input logic [31:0] exp, input bit cti, input bit dn);
    int n = 0;
    op = o; rs = a; rt = b; rd = d; sh = s; imm = im; tgt = tg;
    in_valid = 1'b1; done_in = dn;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
    q1.push_back({24'h0, 8'(exp_ptr), exp});
    exp_ptr++; exp_cnt++;
    if (DS && cti) begin
      q1.push_back({24'h0, 8'(exp_ptr), 32'h0});
      exp_ptr++; exp_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; done_in = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_ptr = 0; exp_cnt = 0;
  endtask

  initial begin
    nrst = 0; start = 0; done_in = 0; in_valid = 0; start2 = 0; valid2 = 0;
    op = 0; rs = 0; rt = 0; rd = 0; sh = 0; imm = 0; tgt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {mem_we, busy, finished, err, err_code, in_ready, count, mem_addr, mem_wdata}, 64'h0);
    chk("reset_outputs2", {we2, busy2, fin2, err2, ec2, r2, cnt2}, 64'h0);
    @(posedge clk); #1;
    nrst = 1;
    pulse_start();
    chk("load_ready", {busy, in_ready, finished, err}, 4'b1100);
    send(5'd8, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 8'h0, 32'h20220005, 1'b0, 1'b0);
    chk("count_after_addi", count, 64'd1);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 8'h0, 32'h00221820, 1'b0, 1'b0);
    chk("count_after_add", count, 64'd2);
    send(5'd25, 5'd5, 5'd5, 5'd5, 5'd5, 16'hFFFF, 8'hFF, 32'h00000000, 1'b0, 1'b0);
    send(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 8'h0, 32'hAFA80004, 1'b0, 1'b0);
    send(5'd21, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0, 8'd2, 32'h1022FFFD, 1'b1, 1'b0);
    send(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 8'h40, 32'h0C000040, 1'b1, 1'b0);
    chk("jal_slot_ready", 64'(in_ready), 64'(!DS));
    send(5'd5, 5'd7, 5'd2, 5'd4, 5'd3, 16'h0, 8'h0, 32'h000220C0, 1'b0, 1'b0);
    send(5'd14, 5'd5, 5'd3, 5'd0, 5'd0, 16'h1234, 8'h0, 32'h3C031234, 1'b0, 1'b0);
    send(5'd22, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0, 8'(exp_ptr + 5), 32'h14640004, 1'b1, 1'b0);
    send(5'd7, 5'd31, 5'd9, 5'd9, 5'd9, 16'h5555, 8'h0, 32'h03E00008, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("count_program", count, 64'(exp_cnt));
    chk("q1_drained", 64'(q1.size()), 64'd0);
    op = 5'd27; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("illegal_op", {err, err_code, in_ready, busy}, {1'b1, 2'b01, 1'b0, 1'b0});
    pulse_start();
    chk("restart", {err, err_code, busy, finished, count}, {1'b0, 2'b00, 1'b1, 1'b0, 9'd0});
    send(5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 8'h0, 32'h3422FFFF, 1'b0, 1'b1);
    chk("done_with_accept", {finished, busy, in_ready, mem_we, mem_addr}, {1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
    op = 5'd0; in_valid = 1'b1;
    repeat (2) @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_sticky", {finished, count}, {1'b1, 9'd1});
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    op = 5'd25;
    for (int i = 0; i < 4; i++) q2.push_back({30'h0, 2'(i), 32'h0});
    valid2 = 1'b1;
    repeat (4) @(posedge clk); #1;
    valid2 = 1'b0;
    chk("full_state", {fin2, r2, busy2, cnt2}, {1'b1, 1'b0, 1'b0, 3'd4});
    valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0;
    chk("full_overflow", {err2, ec2, fin2}, {1'b1, 2'b10, 1'b0});
    pulse_start();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 8'h0, 32'h00221820, 1'b0, 1'b0);
    nrst = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_load", {mem_we, busy, finished, err, err_code, in_ready, count, mem_addr, mem_wdata}, 64'h0);
    nrst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("queues_drained", 64'(q1.size() + q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
